mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_if.sv | 73 +++++++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU, the DMA engine, the shared memory and mem_port_arbiter.
// With ARB_STATS_EN defined the bundle also carries the transfer/forced-win counters.
interface mem_port_arbiter_if #(
   parameter int WORD_SIZE = 16
);

   logic                 cpu_req;
   logic                 cpu_we;
   logic [WORD_SIZE-1:0] cpu_addr;
   logic [WORD_SIZE-1:0] cpu_wdata;
   logic                 cpu_grant;
   logic                 cpu_done;
   logic [WORD_SIZE-1:0] cpu_rdata;

   logic                 dma_req;
   logic                 dma_we;
   logic [WORD_SIZE-1:0] dma_addr;
   logic [WORD_SIZE-1:0] dma_wdata;
   logic                 dma_grant;
   logic                 dma_done;
   logic [WORD_SIZE-1:0] dma_rdata;

   logic                 readM;
   logic                 writeM;
   logic [WORD_SIZE-1:0] address;
   logic [WORD_SIZE-1:0] mem_wdata;
   logic [WORD_SIZE-1:0] mem_rdata;

`ifdef ARB_STATS_EN
   logic [WORD_SIZE-1:0] cpu_xfer_cnt;
   logic [WORD_SIZE-1:0] dma_xfer_cnt;
   logic [WORD_SIZE-1:0] forced_cnt;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      input  mem_rdata,
      output cpu_grant, cpu_done, cpu_rdata,
      output dma_grant, dma_done, dma_rdata,
      output readM, writeM, address, mem_wdata,
      output cpu_xfer_cnt, dma_xfer_cnt, forced_cnt
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      output mem_rdata,
      input  cpu_grant, cpu_done, cpu_rdata,
      input  dma_grant, dma_done, dma_rdata,
      input  readM, writeM, address, mem_wdata,
      input  cpu_xfer_cnt, dma_xfer_cnt, forced_cnt
   );
`else
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      input  mem_rdata,
      output cpu_grant, cpu_done, cpu_rdata,
      output dma_grant, dma_done, dma_rdata,
      output readM, writeM, address, mem_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      output mem_rdata,
      input  cpu_grant, cpu_done, cpu_rdata,
      input  dma_grant, dma_done, dma_rdata,
      input  readM, writeM, address, mem_wdata
   );
`endif

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between CPU and DMA, CPU first
// with a DMA starvation guard. ARB_STATS_EN adds transfer and forced-win counters.
module mem_port_arbiter #(
   parameter int WORD_SIZE    = 16,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   localparam logic [3:0] LAT_LAST   = 4'(MEM_LATENCY - 1);
   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t               r_state;
   state_t               w_state_nxt;

   logic                 r_owner_dma;
   logic                 r_we;
   logic [WORD_SIZE-1:0] r_addr;
   logic [WORD_SIZE-1:0] r_wdata;
   logic [3:0]           r_cnt;
   logic [3:0]           r_streak;

   logic                 r_cpu_grant, r_dma_grant, r_cpu_done, r_dma_done;
   logic                 r_readM, r_writeM;
   logic [WORD_SIZE-1:0] r_address, r_mem_wdata, r_cpu_rdata, r_dma_rdata;

   logic                 w_start, w_forced, w_dma_wins, w_last_beat, w_busy_nxt;
   logic                 w_owner_nxt, w_we_nxt;
   logic [WORD_SIZE-1:0] w_addr_nxt, w_wdata_nxt;
   logic [3:0]           w_cnt_nxt, w_streak_nxt;

   logic                 w_cpu_grant_nxt, w_dma_grant_nxt, w_cpu_done_nxt, w_dma_done_nxt;
   logic                 w_readM_nxt, w_writeM_nxt;
   logic [WORD_SIZE-1:0] w_address_nxt, w_mem_wdata_nxt, w_cpu_rdata_nxt, w_dma_rdata_nxt;

   // DMA is forced through once the CPU has beaten it STARVE_LIMIT times in a row.
   assign w_start     = (r_state == S_IDLE) && (bus.cpu_req || bus.dma_req);
   assign w_forced    = bus.cpu_req && bus.dma_req && (r_streak == STARVE_MAX);
   assign w_dma_wins  = bus.dma_req && (!bus.cpu_req || w_forced);
   assign w_last_beat = (r_state == S_BUSY) && (r_cnt == '0);

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
         S_BUSY:  if (r_cnt == '0) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_owner_nxt  = r_owner_dma;
      w_we_nxt     = r_we;
      w_addr_nxt   = r_addr;
      w_wdata_nxt  = r_wdata;
      w_cnt_nxt    = r_cnt;
      w_streak_nxt = r_streak;
      if (w_start) begin
         w_owner_nxt = w_dma_wins;
         w_we_nxt    = w_dma_wins ? bus.dma_we    : bus.cpu_we;
         w_addr_nxt  = w_dma_wins ? bus.dma_addr  : bus.cpu_addr;
         w_wdata_nxt = w_dma_wins ? bus.dma_wdata : bus.cpu_wdata;
         w_cnt_nxt   = LAT_LAST;
         if (w_dma_wins || !bus.dma_req)
            w_streak_nxt = '0;
         else if (r_streak != STARVE_MAX)
            w_streak_nxt = r_streak + 4'd1;
      end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
         w_cnt_nxt = r_cnt - 4'd1;
      end
   end

   // Outputs are decoded from the next state so they can be registered with it.
   always_comb begin
      w_busy_nxt      = (w_state_nxt == S_BUSY);
      w_cpu_grant_nxt = (w_state_nxt != S_IDLE) && !w_owner_nxt;
      w_dma_grant_nxt = (w_state_nxt != S_IDLE) &&  w_owner_nxt;
      w_cpu_done_nxt  = (w_state_nxt == S_DONE) && !w_owner_nxt;
      w_dma_done_nxt  = (w_state_nxt == S_DONE) &&  w_owner_nxt;
      w_readM_nxt     = w_busy_nxt && !w_we_nxt;
      w_writeM_nxt    = w_busy_nxt &&  w_we_nxt;
      w_address_nxt   = w_busy_nxt ? w_addr_nxt : '0;
      w_mem_wdata_nxt = (w_busy_nxt && w_we_nxt) ? w_wdata_nxt : '0;
      w_cpu_rdata_nxt = r_cpu_rdata;
      w_dma_rdata_nxt = r_dma_rdata;
      if (w_last_beat && !r_we) begin
         if (r_owner_dma) w_dma_rdata_nxt = bus.mem_rdata;
         else             w_cpu_rdata_nxt = bus.mem_rdata;
      end
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_owner_dma <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_streak    <= '0;
         r_cpu_grant <= 1'b0;
         r_dma_grant <= 1'b0;
         r_cpu_done  <= 1'b0;
         r_dma_done  <= 1'b0;
         r_readM     <= 1'b0;
         r_writeM    <= 1'b0;
         r_address   <= '0;
         r_mem_wdata <= '0;
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_owner_dma <= w_owner_nxt;
         r_we        <= w_we_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_cnt       <= w_cnt_nxt;
         r_streak    <= w_streak_nxt;
         r_cpu_grant <= w_cpu_grant_nxt;
         r_dma_grant <= w_dma_grant_nxt;
         r_cpu_done  <= w_cpu_done_nxt;
         r_dma_done  <= w_dma_done_nxt;
         r_readM     <= w_readM_nxt;
         r_writeM    <= w_writeM_nxt;
         r_address   <= w_address_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
         r_cpu_rdata <= w_cpu_rdata_nxt;
         r_dma_rdata <= w_dma_rdata_nxt;
      end
   end

   assign bus.cpu_grant = r_cpu_grant;
   assign bus.dma_grant = r_dma_grant;
   assign bus.cpu_done  = r_cpu_done;
   assign bus.dma_done  = r_dma_done;
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.dma_rdata = r_dma_rdata;
   assign bus.readM     = r_readM;
   assign bus.writeM    = r_writeM;
   assign bus.address   = r_address;
   assign bus.mem_wdata = r_mem_wdata;

`ifdef ARB_STATS_EN
   localparam logic [WORD_SIZE-1:0] STAT_ONE = WORD_SIZE'(1);

   logic [WORD_SIZE-1:0] r_cpu_xfer_cnt, r_dma_xfer_cnt, r_forced_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cpu_xfer_cnt <= '0;
         r_dma_xfer_cnt <= '0;
         r_forced_cnt   <= '0;
      end else begin
         if (w_cpu_done_nxt)         r_cpu_xfer_cnt <= r_cpu_xfer_cnt + STAT_ONE;
         if (w_dma_done_nxt)         r_dma_xfer_cnt <= r_dma_xfer_cnt + STAT_ONE;
         if (w_start && w_forced)    r_forced_cnt   <= r_forced_cnt + STAT_ONE;
      end
   end

   assign bus.cpu_xfer_cnt = r_cpu_xfer_cnt;
   assign bus.dma_xfer_cnt = r_dma_xfer_cnt;
   assign bus.forced_cnt   = r_forced_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios, then random traffic
// checked against a transaction-level model. Counter checks run when ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

   localparam int L = 2;
   localparam int S = 4;

   logic clk;
   logic reset_n;

   mem_port_arbiter_if #(.WORD_SIZE(16)) bus ();

   mem_port_arbiter #(
      .WORD_SIZE   (16),
      .MEM_LATENCY (L),
      .STARVE_LIMIT(S)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory device: fixed read value in directed tests, a small RAM during random traffic.
   logic        use_model = 1'b0;
   logic [15:0] fixed_rdata = 16'h0;
   logic [15:0] tb_mem [16] = '{default: 16'h0};

   assign bus.mem_rdata = use_model ? tb_mem[bus.address[3:0]] : fixed_rdata;

   always @(posedge clk)
      if (use_model && bus.writeM) tb_mem[bus.address[3:0]] <= bus.mem_wdata;

   int n_tests = 0;
   int n_fail  = 0;

   int ob_read, ob_write, ob_cgrant, ob_dgrant, ob_cdone, ob_ddone;
   int first_cdone, first_ddone, n_grants;
   logic [15:0] order;
   bit addr_ok, wdata_ok;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      reset_n     = 1'b0;
      bus.cpu_req = 1'b0;
      bus.dma_req = 1'b0;
      repeat (2) cycle();
      reset_n = 1'b1;
   endtask

   // Watches n cycles acting as both requesters: drops req on done, optionally re-raises next cycle.
   task automatic watch(input int n, input bit rearm);
      bit prev_any, c_rearm, d_rearm;
      ob_read = 0; ob_write = 0; ob_cgrant = 0; ob_dgrant = 0; ob_cdone = 0; ob_ddone = 0;
      first_cdone = 0; first_ddone = 0; n_grants = 0; order = '0;
      addr_ok = 1'b1; wdata_ok = 1'b1;
      c_rearm = 1'b0; d_rearm = 1'b0;
      prev_any = bus.cpu_grant || bus.dma_grant;
      for (int c = 1; c <= n; c++) begin
         cycle();
         if (bus.readM)     ob_read++;
         if (bus.writeM)    ob_write++;
         if (bus.cpu_grant) ob_cgrant++;
         if (bus.dma_grant) ob_dgrant++;
         if (bus.readM || bus.writeM) begin
            if (bus.address !== (bus.dma_grant ? bus.dma_addr : bus.cpu_addr)) addr_ok = 1'b0;
            if (bus.mem_wdata !== (bus.writeM ? (bus.dma_grant ? bus.dma_wdata : bus.cpu_wdata)
                                              : 16'h0)) wdata_ok = 1'b0;
         end
         if ((bus.cpu_grant || bus.dma_grant) && !prev_any) begin
            if (n_grants < 16) order[n_grants] = bus.dma_grant;
            n_grants++;
         end
         prev_any = bus.cpu_grant || bus.dma_grant;
         if (c_rearm) begin bus.cpu_req = 1'b1; c_rearm = 1'b0; end
         if (d_rearm) begin bus.dma_req = 1'b1; d_rearm = 1'b0; end
         if (bus.cpu_done) begin
            ob_cdone++;
            if (first_cdone == 0) first_cdone = c;
            bus.cpu_req = 1'b0;
            c_rearm = rearm;
         end
         if (bus.dma_done) begin
            ob_ddone++;
            if (first_ddone == 0) first_ddone = c;
            bus.dma_req = 1'b0;
            d_rearm = rearm;
         end
      end
   endtask

   task automatic random_phase(input int n_cycles);
      logic [15:0] gold [16];
      logic [15:0] exp_c, exp_d, o_addr, o_wdata;
      int  streak_m, start_c, strobes, wait_c, wait_d, max_wait;
      bit  prev_any, p_c, p_d, own_dma, o_we, drop_c, drop_d;
      for (int i = 0; i < 16; i++) gold[i] = 16'h0;
      exp_c = 16'h0; exp_d = 16'h0; o_addr = 16'h0; o_wdata = 16'h0; o_we = 1'b0;
      streak_m = 0; start_c = 0; strobes = 0; wait_c = 0; wait_d = 0; max_wait = 0;
      prev_any = 1'b0; own_dma = 1'b0;
      use_model = 1'b1;
      for (int c = 1; c <= n_cycles; c++) begin
         p_c = bus.cpu_req;
         p_d = bus.dma_req;
         cycle();
         drop_c = 1'b0;
         drop_d = 1'b0;
         check("rnd_grant_onehot", 32'(bus.cpu_grant & bus.dma_grant), 32'd0);
         check("rnd_strobe_excl",  32'(bus.readM & bus.writeM), 32'd0);
         if ((bus.cpu_grant || bus.dma_grant) && !prev_any) begin
            own_dma = p_d && (!p_c || streak_m == S);
            check("rnd_winner_is_dma", 32'(bus.dma_grant), 32'(own_dma));
            if (own_dma || !p_d) streak_m = 0;
            else if (streak_m < S) streak_m++;
            o_we    = own_dma ? bus.dma_we    : bus.cpu_we;
            o_addr  = own_dma ? bus.dma_addr  : bus.cpu_addr;
            o_wdata = own_dma ? bus.dma_wdata : bus.cpu_wdata;
            start_c = c;
            strobes = 0;
         end
         prev_any = bus.cpu_grant || bus.dma_grant;
         if (bus.readM || bus.writeM) begin
            strobes++;
            check("rnd_address",   32'(bus.address), 32'(o_addr));
            check("rnd_is_write",  32'(bus.writeM), 32'(o_we));
            check("rnd_mem_wdata", 32'(bus.mem_wdata), o_we ? 32'(o_wdata) : 32'd0);
         end
         if (bus.cpu_done || bus.dma_done) begin
            check("rnd_done_owner", 32'(bus.dma_done), 32'(own_dma));
            check("rnd_latency",    32'(c - start_c), 32'(L));
            check("rnd_strobe_cnt", 32'(strobes), 32'(L));
            if (o_we)         gold[o_addr[3:0]] = o_wdata;
            else if (own_dma) exp_d = gold[o_addr[3:0]];
            else              exp_c = gold[o_addr[3:0]];
            check("rnd_cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_c));
            check("rnd_dma_rdata", 32'(bus.dma_rdata), 32'(exp_d));
            if (own_dma) begin bus.dma_req = 1'b0; drop_d = 1'b1; end
            else         begin bus.cpu_req = 1'b0; drop_c = 1'b1; end
         end
         if (!bus.cpu_req && !drop_c && $urandom_range(0, 1) == 1) begin
            bus.cpu_we    = 1'($urandom_range(0, 1));
            bus.cpu_addr  = 16'($urandom);
            bus.cpu_wdata = 16'($urandom);
            bus.cpu_req   = 1'b1;
         end
         if (!bus.dma_req && !drop_d && $urandom_range(0, 1) == 1) begin
            bus.dma_we    = 1'($urandom_range(0, 1));
            bus.dma_addr  = 16'($urandom);
            bus.dma_wdata = 16'($urandom);
            bus.dma_req   = 1'b1;
         end
         wait_c = bus.cpu_req ? wait_c + 1 : 0;
         wait_d = bus.dma_req ? wait_d + 1 : 0;
         if (wait_c > max_wait) max_wait = wait_c;
         if (wait_d > max_wait) max_wait = wait_d;
      end
      check("rnd_wait_bounded", 32'(max_wait <= 40), 32'd1);
      bus.cpu_req = 1'b0;
      bus.dma_req = 1'b0;
      use_model   = 1'b0;
      repeat (6) cycle();
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: run did not reach its summary line");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n       = 1'b0;
      bus.cpu_req   = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req   = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
      @(negedge clk);
      apply_reset();

      check("rst_cpu_grant", 32'(bus.cpu_grant), 32'd0);
      check("rst_dma_grant", 32'(bus.dma_grant), 32'd0);
      check("rst_done",      32'(bus.cpu_done | bus.dma_done), 32'd0);
      check("rst_strobes",   32'(bus.readM | bus.writeM), 32'd0);
      check("rst_address",   32'(bus.address), 32'd0);
      check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
      check("rst_dma_rdata", 32'(bus.dma_rdata), 32'd0);

      // CPU read alone
      fixed_rdata = 16'hBEEF;
      bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010; bus.cpu_req = 1'b1;
      watch(6, 1'b0);
      check("c_rd_readM_cycles", 32'(ob_read), 32'd2);
      check("c_rd_writeM",       32'(ob_write), 32'd0);
      check("c_rd_address",      32'(addr_ok), 32'd1);
      check("c_rd_grant_cycles", 32'(ob_cgrant), 32'd3);
      check("c_rd_dma_grant",    32'(ob_dgrant), 32'd0);
      check("c_rd_done_pulses",  32'(ob_cdone), 32'd1);
      check("c_rd_done_cycle",   32'(first_cdone), 32'(L + 1));
      check("c_rd_cpu_rdata",    32'(bus.cpu_rdata), 32'h0000BEEF);
      check("c_rd_dma_rdata",    32'(bus.dma_rdata), 32'd0);

      // DMA write alone
      fixed_rdata = 16'hDEAD;
      bus.dma_we = 1'b1; bus.dma_addr = 16'h0200; bus.dma_wdata = 16'h1234; bus.dma_req = 1'b1;
      watch(6, 1'b0);
      check("d_wr_writeM_cycles", 32'(ob_write), 32'd2);
      check("d_wr_readM",         32'(ob_read), 32'd0);
      check("d_wr_address",       32'(addr_ok), 32'd1);
      check("d_wr_mem_wdata",     32'(wdata_ok), 32'd1);
      check("d_wr_grant_cycles",  32'(ob_dgrant), 32'd3);
      check("d_wr_done_pulses",   32'(ob_ddone), 32'd1);
      check("d_wr_cpu_rdata",     32'(bus.cpu_rdata), 32'h0000BEEF);
      check("d_wr_dma_rdata",     32'(bus.dma_rdata), 32'd0);

      // Simultaneous single requests from reset
      apply_reset();
      fixed_rdata = 16'h5A5A;
      bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0030;
      bus.dma_we = 1'b0; bus.dma_addr = 16'h0040;
      bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
      watch(10, 1'b0);
      check("sim_grants",     32'(n_grants), 32'd2);
      check("sim_first_cpu",  32'(order[0]), 32'd0);
      check("sim_second_dma", 32'(order[1]), 32'd1);
      check("sim_done_gap",   32'(first_ddone - first_cdone), 32'(L + 2));
      check("sim_cpu_rdata",  32'(bus.cpu_rdata), 32'h00005A5A);
      check("sim_dma_rdata",  32'(bus.dma_rdata), 32'h00005A5A);
      check("sim_address",    32'(addr_ok), 32'd1);

      // Continuous contention: starvation guard lets DMA through every fifth grant
      apply_reset();
      bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
      watch(10 * (L + 2), 1'b1);
      bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
      check("starve_grants", 32'(n_grants), 32'd10);
      for (int i = 0; i < 10; i++)
         check($sformatf("starve_order_%0d", i), 32'(order[i]), 32'((i % (S + 1)) == S));
`ifdef ARB_STATS_EN
      check("stats_starve_cpu",    32'(bus.cpu_xfer_cnt), 32'd8);
      check("stats_starve_dma",    32'(bus.dma_xfer_cnt), 32'd2);
      check("stats_starve_forced", 32'(bus.forced_cnt), 32'd2);
`endif
      repeat (4) cycle();

      // Reset in the second BUSY cycle of a CPU read
      apply_reset();
      fixed_rdata = 16'h7777;
      bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0055; bus.cpu_req = 1'b1;
      cycle();
      check("abort_busy_readM", 32'(bus.readM), 32'd1);
      cycle();
      reset_n = 1'b0;
      cycle();
      check("abort_readM",     32'(bus.readM), 32'd0);
      check("abort_cpu_grant", 32'(bus.cpu_grant), 32'd0);
      check("abort_cpu_done",  32'(bus.cpu_done), 32'd0);
      check("abort_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
      cycle();
      check("abort_hold_done", 32'(bus.cpu_done), 32'd0);
      reset_n = 1'b1;
      watch(5, 1'b0);
      check("abort_retry_readM", 32'(ob_read), 32'd2);
      check("abort_retry_grant", 32'(ob_cgrant), 32'd3);
      check("abort_retry_done",  32'(ob_cdone), 32'd1);
      check("abort_retry_rdata", 32'(bus.cpu_rdata), 32'h00007777);

`ifdef ARB_STATS_EN
      // Uncontended traffic: three CPU and two DMA transfers
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         if (k < 3) begin bus.cpu_we = 1'b0; bus.cpu_addr = 16'(k); bus.cpu_req = 1'b1; end
         else       begin bus.dma_we = 1'b1; bus.dma_addr = 16'(k); bus.dma_req = 1'b1; end
         watch(5, 1'b0);
      end
      check("stats_cpu_xfer", 32'(bus.cpu_xfer_cnt), 32'd3);
      check("stats_dma_xfer", 32'(bus.dma_xfer_cnt), 32'd2);
      check("stats_forced",   32'(bus.forced_cnt), 32'd0);
`endif

      apply_reset();
      random_phase(400);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
